// File: rtl/fx_pkg.sv
// Shared constants and helpers for the fixed-point requantiser.
//   RND_*  : rounding-mode encodings carried on i_rnd_mode
//   OVF_*  : overflow-mode encodings carried on i_ovf_mode
//   fx_mid_width : width of the quantised intermediate so that no internal wrap occurs
package fx_pkg;

  localparam logic [1:0] RND_TRUNC   = 2'd0;
  localparam logic [1:0] RND_HALF_UP = 2'd1;
  localparam logic [1:0] RND_CONV    = 2'd2;

  localparam logic OVF_WRAP = 1'b0;
  localparam logic OVF_SAT  = 1'b1;

  // One guard bit for round-up carry, plus headroom for any left shift.
  function automatic int fx_mid_width(input int iw, input int i_f, input int o_f);
    return (o_f > i_f) ? (iw + 1 + (o_f - i_f)) : (iw + 1);
  endfunction

endpackage

// File: rtl/fx_requant_pipe_if.sv
// Sample/flag bundle of the requantiser.
//   i_valid, i_data, i_rnd_mode, i_ovf_mode, i_clr : producer -> requantiser
//   o_valid, o_data, o_ovf, o_ovf_sticky, o_ovf_cnt : requantiser -> consumer
// master: the side that drives samples; slave: the requantiser itself.
interface fx_requant_pipe_if #(
  parameter int IW    = 14,
  parameter int OW    = 11,
  parameter int CNT_W = 16
);
  logic             i_valid;
  logic [IW-1:0]    i_data;
  logic [1:0]       i_rnd_mode;
  logic             i_ovf_mode;
  logic             i_clr;
  logic             o_valid;
  logic [OW-1:0]    o_data;
  logic             o_ovf;
  logic             o_ovf_sticky;
  logic [CNT_W-1:0] o_ovf_cnt;

  modport master (
    output i_valid, i_data, i_rnd_mode, i_ovf_mode, i_clr,
    input  o_valid, o_data, o_ovf, o_ovf_sticky, o_ovf_cnt
  );

  modport slave (
    input  i_valid, i_data, i_rnd_mode, i_ovf_mode, i_clr,
    output o_valid, o_data, o_ovf, o_ovf_sticky, o_ovf_cnt
  );
endinterface

// File: rtl/fx_delay_line.sv
// Valid-qualified delay line of DEPTH stages; DEPTH=0 is a plain wire.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_valid/i_data : stage input
//   o_valid/o_data : output DEPTH cycles later
// Data registers load only when the valid entering them is high.
module fx_delay_line #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  if (DEPTH == 0) begin : g_wire
    assign o_valid = i_valid;
    assign o_data  = i_data;
  end else begin : g_regs
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [W-1:0]     dat_q [DEPTH];
    logic [W-1:0]     dat_d [DEPTH];

    always_comb begin
      vld_d[0] = i_valid;
      dat_d[0] = i_valid ? i_data : dat_q[0];
      for (int i = 1; i < DEPTH; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        vld_q <= '0;
        for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
      end else begin
        vld_q <= vld_d;
        for (int i = 0; i < DEPTH; i++) dat_q[i] <= dat_d[i];
      end
    end

    assign o_valid = vld_q[DEPTH-1];
    assign o_data  = dat_q[DEPTH-1];
  end

endmodule

// File: rtl/fx_requant_pipe.sv
// Pipelined signed fixed-point requantiser (IW.IF -> OW.OF).
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : i_valid/i_data/i_rnd_mode/i_ovf_mode/i_clr in,
//                  o_valid/o_data/o_ovf/o_ovf_sticky/o_ovf_cnt out
// Stage Q rounds/shifts, stage V range-checks, then DELAY extra stages.
// Latency 2+DELAY, one sample per cycle, no backpressure.
module fx_requant_pipe
  import fx_pkg::*;
#(
  parameter int IW    = 14,
  parameter int IF    = 10,
  parameter int OW    = 11,
  parameter int OF    = 8,
  parameter int DELAY = 1,
  parameter int CNT_W = 16
) (
  input logic              i_clk,
  input logic              i_rst,
  fx_requant_pipe_if.slave bus
);

  localparam int D  = IF - OF;
  localparam int MW = fx_mid_width(IW, IF, OF);
  localparam int CW = ((MW > OW) ? MW : OW) + 1;

  if (OW < 2 || IW < 2 || DELAY < 0 || D >= IW) begin : g_bad_params
    $error("fx_requant_pipe: unsupported parameter set");
  end

  // ---------------- Stage Q: quantise ----------------
  logic signed [MW-1:0] in_ext, quant;
  assign in_ext = {{(MW-IW){bus.i_data[IW-1]}}, bus.i_data};

  if (D <= 0) begin : g_lshift
    assign quant = in_ext <<< (-D);
  end else begin : g_rshift
    localparam logic [D-1:0] HalfPat = D'(1) << (D-1);
    logic signed [MW-1:0] rnd_add;

    always_comb begin
      rnd_add = '0;
      case (bus.i_rnd_mode)
        RND_HALF_UP: rnd_add = MW'(HalfPat);
        // Exact tie with an even kept LSB stays put; everything else rounds half-up.
        RND_CONV: begin
          if (!((bus.i_data[D-1:0] == HalfPat) && !bus.i_data[D])) rnd_add = MW'(HalfPat);
        end
        default: rnd_add = '0;
      endcase
    end

    assign quant = (in_ext + rnd_add) >>> D;
  end

  logic                 q_valid_q, q_valid_d;
  logic signed [MW-1:0] q_data_q, q_data_d;
  logic                 q_ovf_mode_q, q_ovf_mode_d;

  always_comb begin
    q_valid_d    = bus.i_valid;
    q_data_d     = q_data_q;
    q_ovf_mode_d = q_ovf_mode_q;
    if (bus.i_valid) begin
      q_data_d     = quant;
      q_ovf_mode_d = bus.i_ovf_mode;
    end
  end

  // ---------------- Stage V: range check ----------------
  localparam logic signed [CW-1:0] VHi = {{(CW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [CW-1:0] VLo = {{(CW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic signed [CW-1:0] v_ext;
  logic                 v_above, v_below;
  logic                 v_valid_q, v_valid_d;
  logic [OW-1:0]        v_data_q, v_data_d;
  logic                 v_ovf_q, v_ovf_d;

  assign v_ext   = {{(CW-MW){q_data_q[MW-1]}}, q_data_q};
  assign v_above = v_ext > VHi;
  assign v_below = v_ext < VLo;

  always_comb begin
    v_valid_d = q_valid_q;
    v_data_d  = v_data_q;
    v_ovf_d   = v_ovf_q;
    if (q_valid_q) begin
      v_ovf_d  = v_above | v_below;
      v_data_d = v_ext[OW-1:0];
      if (q_ovf_mode_q == OVF_SAT) begin
        if (v_above)      v_data_d = VHi[OW-1:0];
        else if (v_below) v_data_d = VLo[OW-1:0];
      end
    end
  end

  // ---------------- Overflow bookkeeping ----------------
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear first, then the event, so a coincident clear+overflow leaves a count of one.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (bus.i_clr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
    if (v_valid_q && v_ovf_q) begin
      sticky_d = 1'b1;
      if (cnt_d != '1) cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      q_valid_q    <= 1'b0;
      q_data_q     <= '0;
      q_ovf_mode_q <= 1'b0;
      v_valid_q    <= 1'b0;
      v_data_q     <= '0;
      v_ovf_q      <= 1'b0;
      sticky_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      q_valid_q    <= q_valid_d;
      q_data_q     <= q_data_d;
      q_ovf_mode_q <= q_ovf_mode_d;
      v_valid_q    <= v_valid_d;
      v_data_q     <= v_data_d;
      v_ovf_q      <= v_ovf_d;
      sticky_q     <= sticky_d;
      cnt_q        <= cnt_d;
    end
  end

  // ---------------- Output delay ----------------
  logic          dly_valid;
  logic [OW:0]   dly_data;

  fx_delay_line #(
    .W     (OW + 1),
    .DEPTH (DELAY)
  ) u_dly (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (v_valid_q),
    .i_data  ({v_ovf_q, v_data_q}),
    .o_valid (dly_valid),
    .o_data  (dly_data)
  );

  assign bus.o_valid      = dly_valid;
  assign bus.o_data       = dly_data[OW-1:0];
  assign bus.o_ovf        = dly_data[OW];
  assign bus.o_ovf_sticky = sticky_q;
  assign bus.o_ovf_cnt    = cnt_q;

endmodule
